// File: rtl/core_executor_if.sv
// rtl/core_executor_if.sv - instruction/register-load bus between instruction processor and core executor
interface core_executor_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-2:0] instruction;
    logic             instrValid;
    logic [3:0]       regChoose;
    logic [WIDTH-1:0] regData;
    logic             stall;
    logic [3:0]       flags;
    logic [WIDTH-1:0] reg0Out;
    logic [WIDTH-1:0] reg1Out;
    logic [WIDTH-1:0] reg2Out;
    logic [WIDTH-1:0] reg3Out;

    modport master (
        output instruction, instrValid, regChoose, regData,
        input  stall, flags, reg0Out, reg1Out, reg2Out, reg3Out
    );

    modport slave (
        input  instruction, instrValid, regChoose, regData,
        output stall, flags, reg0Out, reg1Out, reg2Out, reg3Out
    );
endinterface

// File: rtl/core_executor.sv
// rtl/core_executor.sv - decodes and conditionally executes ALU/MOVI instructions on a 4x16 register file
// with NZCV flags; multiply runs as a 16-step shift-add sequence while holding stall.
module core_executor #(
    parameter int WIDTH       = 16,
    parameter int INSTR_WIDTH = WIDTH - 1,
    parameter int NREGS       = 4
) (
    input  logic          clock,
    input  logic          reset,
    core_executor_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b0110;
    localparam logic [3:0] OP_SHL = 4'b0111;
    localparam logic [3:0] OP_SHR = 4'b1000;
    localparam logic [3:0] OP_MOV = 4'b1001;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_regs [NREGS];
    logic [3:0]           r_flags;
    logic                 r_stall;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [4:0]           r_cnt;
    logic [1:0]           r_mdst;

    logic [INSTR_WIDTH-1:0] w_instr;
    logic                 w_accept;
    logic                 w_is_alu;
    logic [3:0]           w_opcode;
    logic [3:0]           w_cond;
    logic [1:0]           w_dst;
    logic [WIDTH-1:0]     w_op1;
    logic [WIDTH-1:0]     w_op2;
    logic [WIDTH-1:0]     w_movi_cur;
    logic                 w_n, w_z, w_c_flag, w_v_flag;
    logic                 w_cond_ok;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic [WIDTH-1:0]     w_result;
    logic                 w_c;
    logic                 w_v;
    logic                 w_reg_we;
    logic                 w_set_nzcv;
    logic [1:0]           w_wdst;
    logic [3:0]           w_flags_next;
    logic                 w_mul_start;
    logic                 w_mul_done;
    logic [2*WIDTH-1:0]   w_acc_step;
    logic                 w_mul_hi_nz;
    logic [3:0]           w_mul_flags;

    assign w_instr    = bus.instruction;
    assign w_accept   = bus.instrValid & ~r_stall;
    assign w_is_alu   = w_instr[14];
    assign w_opcode   = w_instr[13:10];
    assign w_cond     = w_instr[9:6];
    assign w_dst      = w_instr[5:4];
    assign w_op1      = r_regs[w_instr[3:2]];
    assign w_op2      = r_regs[w_instr[1:0]];
    assign w_movi_cur = r_regs[w_instr[9:8]];

    assign {w_n, w_z, w_c_flag, w_v_flag} = r_flags;

    always_comb begin
        w_cond_ok = 1'b0;
        case (w_cond)
            4'b0000: w_cond_ok = w_z;
            4'b0001: w_cond_ok = ~w_z;
            4'b0010: w_cond_ok = w_c_flag;
            4'b0011: w_cond_ok = ~w_c_flag;
            4'b0100: w_cond_ok = w_n;
            4'b0101: w_cond_ok = ~w_n;
            4'b0110: w_cond_ok = w_v_flag;
            4'b0111: w_cond_ok = ~w_v_flag;
            4'b1000: w_cond_ok = (w_n == w_v_flag);
            4'b1001: w_cond_ok = (w_n != w_v_flag);
            4'b1010: w_cond_ok = 1'b1;
            default: w_cond_ok = 1'b0;
        endcase
    end

    // Carry/borrow come from the extra top bit of these widened results.
    assign w_sum  = {1'b0, w_op1} + {1'b0, w_op2};
    assign w_diff = {1'b0, w_op1} - {1'b0, w_op2};

    always_comb begin
        w_result   = '0;
        w_c        = 1'b0;
        w_v        = 1'b0;
        w_reg_we   = 1'b0;
        w_set_nzcv = 1'b0;
        w_wdst     = w_dst;
        if (w_accept) begin
            if (w_is_alu) begin
                if (w_cond_ok) begin
                    case (w_opcode)
                        OP_ADD: begin
                            w_result   = w_sum[MSB:0];
                            w_c        = w_sum[WIDTH];
                            w_v        = (w_op1[MSB] == w_op2[MSB]) && (w_sum[MSB] != w_op1[MSB]);
                            w_reg_we   = 1'b1;
                            w_set_nzcv = 1'b1;
                        end
                        OP_SUB: begin
                            w_result   = w_diff[MSB:0];
                            w_c        = ~w_diff[WIDTH];
                            w_v        = (w_op1[MSB] != w_op2[MSB]) && (w_diff[MSB] != w_op1[MSB]);
                            w_reg_we   = 1'b1;
                            w_set_nzcv = 1'b1;
                        end
                        OP_AND: begin
                            w_result   = w_op1 & w_op2;
                            w_reg_we   = 1'b1;
                            w_set_nzcv = 1'b1;
                        end
                        OP_OR: begin
                            w_result   = w_op1 | w_op2;
                            w_reg_we   = 1'b1;
                            w_set_nzcv = 1'b1;
                        end
                        OP_XOR: begin
                            w_result   = w_op1 ^ w_op2;
                            w_reg_we   = 1'b1;
                            w_set_nzcv = 1'b1;
                        end
                        OP_NOT: begin
                            w_result   = ~w_op1;
                            w_reg_we   = 1'b1;
                            w_set_nzcv = 1'b1;
                        end
                        OP_SHL: begin
                            w_result   = {w_op1[MSB-1:0], 1'b0};
                            w_c        = w_op1[MSB];
                            w_reg_we   = 1'b1;
                            w_set_nzcv = 1'b1;
                        end
                        OP_SHR: begin
                            w_result   = {1'b0, w_op1[MSB:1]};
                            w_c        = w_op1[0];
                            w_reg_we   = 1'b1;
                            w_set_nzcv = 1'b1;
                        end
                        OP_MOV: begin
                            w_result   = w_op2;
                            w_reg_we   = 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
            end else if (w_instr[12:10] == 3'b000) begin
                w_wdst   = w_instr[9:8];
                w_result = w_instr[13] ? {w_instr[7:0], w_movi_cur[7:0]}
                                       : {w_movi_cur[MSB:8], w_instr[7:0]};
                w_reg_we = 1'b1;
            end
        end
    end

    assign w_flags_next = w_set_nzcv ? {w_result[MSB], ~|w_result, w_c, w_v} : r_flags;

    assign w_mul_start = w_accept & w_is_alu & w_cond_ok & (w_opcode == OP_MUL);
    assign w_mul_done  = (r_state == S_MUL) && (r_cnt == 5'd1);
    assign w_acc_step  = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_hi_nz = |w_acc_step[2*WIDTH-1:WIDTH];
    assign w_mul_flags = {w_acc_step[MSB], ~|w_acc_step[MSB:0], w_mul_hi_nz, w_mul_hi_nz};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_flags  <= '0;
            r_stall  <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_mdst   <= '0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_flags <= w_flags_next;
                    if (w_mul_start) begin
                        r_state  <= S_MUL;
                        r_stall  <= 1'b1;
                        r_acc    <= '0;
                        r_mcand  <= {{WIDTH{1'b0}}, w_op1};
                        r_mplier <= w_op2;
                        r_cnt    <= 5'd16;
                        r_mdst   <= w_dst;
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_step;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - 5'd1;
                    // The 16th step's sum is written back directly, so stall drops on the same edge.
                    if (w_mul_done) begin
                        r_state <= S_IDLE;
                        r_stall <= 1'b0;
                        r_flags <= w_mul_flags;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_stall <= 1'b0;
                end
            endcase

            for (int i = 0; i < NREGS; i++) begin
                if (bus.regChoose[i]) begin
                    r_regs[i] <= bus.regData;
                end else if (w_mul_done && (r_mdst == 2'(i))) begin
                    r_regs[i] <= w_acc_step[MSB:0];
                end else if (w_reg_we && (w_wdst == 2'(i))) begin
                    r_regs[i] <= w_result;
                end
            end
        end
    end

    assign bus.stall   = r_stall;
    assign bus.flags   = r_flags;
    assign bus.reg0Out = r_regs[0];
    assign bus.reg1Out = r_regs[1];
    assign bus.reg2Out = r_regs[2];
    assign bus.reg3Out = r_regs[3];
endmodule

// File: tb/tb_core_executor.sv
// tb/tb_core_executor.sv - directed and randomized checks of core_executor against a behavioural model
module tb_core_executor;
    logic clock;
    logic reset;

    core_executor_if #(.WIDTH(16)) bus ();

    core_executor #(.WIDTH(16), .INSTR_WIDTH(15), .NREGS(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] m_regs [4];
    logic [3:0]  m_flags;
    int          m_busy;
    logic [31:0] m_prod;
    logic [1:0]  m_dst;

    function automatic logic [14:0] alu(int op, int cond, int d, int a, int b);
        logic [14:0] w;
        w = {1'b1, 4'(op), 4'(cond), 2'(d), 2'(a), 2'(b)};
        return w;
    endfunction

    function automatic logic [14:0] movi(int hi, int d, int imm);
        logic [14:0] w;
        w = {1'b0, 1'(hi), 3'b000, 2'(d), 8'(imm)};
        return w;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 16'h0;
        m_flags = 4'h0;
        m_busy  = 0;
        m_prod  = 32'h0;
        m_dst   = 2'd0;
    endtask

    function automatic bit cond_ok(logic [3:0] cond, logic [3:0] f);
        bit n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return n == v;
            4'd9:  return n != v;
            4'd10: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step(logic [14:0] ins, logic v, logic [3:0] rc, logic [15:0] rd);
        int a, b, r, sa, sb, sr, d;
        bit wr, fw, c, ov;
        logic [15:0] rr;
        wr = 0; fw = 0; c = 0; ov = 0; r = 0; d = 0;
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_regs[m_dst] = m_prod[15:0];
                m_flags = {m_prod[15], m_prod[15:0] == 16'h0, m_prod[31:16] != 16'h0, m_prod[31:16] != 16'h0};
            end
        end else if (v) begin
            if (ins[14]) begin
                d  = int'(ins[5:4]);
                a  = int'(m_regs[ins[3:2]]);
                b  = int'(m_regs[ins[1:0]]);
                sa = $signed(m_regs[ins[3:2]]);
                sb = $signed(m_regs[ins[1:0]]);
                if (cond_ok(ins[9:6], m_flags)) begin
                    case (ins[13:10])
                        4'd0: begin r = a + b; c = r > 65535; sr = sa + sb; ov = sr > 32767 || sr < -32768; wr = 1; fw = 1; end
                        4'd1: begin r = a - b; c = a >= b; sr = sa - sb; ov = sr > 32767 || sr < -32768; wr = 1; fw = 1; end
                        4'd2: begin r = a & b; wr = 1; fw = 1; end
                        4'd3: begin r = a | b; wr = 1; fw = 1; end
                        4'd5: begin r = a ^ b; wr = 1; fw = 1; end
                        4'd4: begin m_prod = 32'(longint'(a) * longint'(b)); m_dst = 2'(d); m_busy = 16; end
                        4'd6: begin r = 65535 - a; wr = 1; fw = 1; end
                        4'd7: begin r = a * 2; c = a >= 32768; wr = 1; fw = 1; end
                        4'd8: begin r = a / 2; c = (a % 2) != 0; wr = 1; fw = 1; end
                        4'd9: begin r = b; wr = 1; end
                        default: ;
                    endcase
                end
                rr = 16'(r);
                if (wr) m_regs[d] = rr;
                if (fw) m_flags = {rr[15], rr == 16'h0, c, ov};
            end else if (ins[12:10] == 3'b000) begin
                if (ins[13]) m_regs[ins[9:8]][15:8] = ins[7:0];
                else         m_regs[ins[9:8]][7:0]  = ins[7:0];
            end
        end
        for (int i = 0; i < 4; i++) if (rc[i]) m_regs[i] = rd;
    endtask

    task automatic compare_all();
        check("reg0", bus.reg0Out, m_regs[0]);
        check("reg1", bus.reg1Out, m_regs[1]);
        check("reg2", bus.reg2Out, m_regs[2]);
        check("reg3", bus.reg3Out, m_regs[3]);
        check("flags", bus.flags, m_flags);
        check("stall", bus.stall, m_busy != 0);
    endtask

    task automatic cyc(logic [14:0] ins, logic v, logic [3:0] rc, logic [15:0] rd);
        bus.instruction = ins;
        bus.instrValid  = v;
        bus.regChoose   = rc;
        bus.regData     = rd;
        @(posedge clock);
        model_step(ins, v, rc, rd);
        @(negedge clock);
        compare_all();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, k;
        logic [14:0] ins;
        reset = 1'b1;
        bus.instruction = '0;
        bus.instrValid  = 1'b0;
        bus.regChoose   = '0;
        bus.regData     = '0;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // async reset clears preloaded registers before the next edge
        cyc('0, 1'b0, 4'hF, 16'hABCD);
        check("preload_r3", bus.reg3Out, 16'hABCD);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("reset_r0", bus.reg0Out, 16'h0);
        check("reset_r2", bus.reg2Out, 16'h0);
        check("reset_flags", bus.flags, 4'h0);
        check("reset_stall", bus.stall, 1'b0);
        @(negedge clock);
        reset = 1'b0;

        cyc('0, 1'b0, 4'b0001, 16'd13);
        cyc('0, 1'b0, 4'b0100, 16'd10);
        cyc(alu(0, 10, 0, 0, 2), 1'b1, 4'h0, 16'h0);
        check("add_al_r0", bus.reg0Out, 16'd23);
        check("add_al_flags", bus.flags, 4'b0000);
        cyc(alu(0, 11, 0, 0, 0), 1'b1, 4'h0, 16'h0);
        check("add_nv_r0", bus.reg0Out, 16'd23);

        cyc('0, 1'b0, 4'b0001, 16'h7FFF);
        cyc('0, 1'b0, 4'b0010, 16'h0001);
        cyc(alu(0, 10, 0, 0, 1), 1'b1, 4'h0, 16'h0);
        check("ovf_r0", bus.reg0Out, 16'h8000);
        check("ovf_flags", bus.flags, 4'b1001);
        cyc(alu(1, 10, 1, 1, 1), 1'b1, 4'h0, 16'h0);
        check("sub_r1", bus.reg1Out, 16'h0);
        check("sub_flags", bus.flags, 4'b0110);
        cyc(alu(9, 0, 3, 0, 0), 1'b1, 4'h0, 16'h0);
        check("moveq_r3", bus.reg3Out, 16'h8000);

        cyc('0, 1'b0, 4'b0001, 16'd13);
        cyc('0, 1'b0, 4'b0100, 16'd10);
        cyc('0, 1'b0, 4'b0010, 16'd3);
        cyc(alu(4, 10, 0, 0, 2), 1'b1, 4'h0, 16'h0);
        check("mul_stall_rise", bus.stall, 1'b1);
        n = 1;
        k = 0;
        while (bus.stall && k < 40) begin
            cyc(alu(0, 10, 1, 1, 1), 1'b1, 4'h0, 16'h0);
            k++;
            if (bus.stall) n++;
        end
        check("mul_stall_cycles", n, 16);
        check("mul_r0", bus.reg0Out, 16'd130);
        check("mul_r1_held", bus.reg1Out, 16'd3);
        cyc(alu(0, 10, 1, 1, 1), 1'b1, 4'h0, 16'h0);
        check("post_mul_add_r1", bus.reg1Out, 16'd6);

        cyc(movi(0, 1, 8'hFE), 1'b1, 4'h0, 16'h0);
        check("movi_lo_r1", bus.reg1Out, 16'h00FE);
        cyc(movi(1, 1, 8'h12), 1'b1, 4'h0, 16'h0);
        check("movi_hi_r1", bus.reg1Out, 16'h12FE);
        check("movi_flags", bus.flags, 4'b0000);
        cyc({1'b0, 1'b0, 3'b001, 2'd1, 8'h55}, 1'b1, 4'h0, 16'h0);
        check("movi_nop_r1", bus.reg1Out, 16'h12FE);

        // reset in the middle of a multiply aborts it without write-back
        cyc('0, 1'b0, 4'b0001, 16'd13);
        cyc(alu(4, 10, 0, 0, 2), 1'b1, 4'h0, 16'h0);
        repeat (7) cyc('0, 1'b0, 4'h0, 16'h0);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("abort_stall", bus.stall, 1'b0);
        check("abort_r0", bus.reg0Out, 16'h0);
        #1 reset = 1'b0;
        cyc(alu(0, 10, 0, 0, 0), 1'b1, 4'b0001, 16'd5);
        check("extload_priority_r0", bus.reg0Out, 16'd5);

        repeat (3000) begin
            ins = 15'($urandom);
            if ($urandom_range(0, 2) == 0) ins[9:6] = 4'd10;
            cyc(ins, $urandom_range(0, 4) != 0,
                ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
                16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
